// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pkg
// Brief    : Immediate-extension mode encodings shared with the decoder.
// Revision : 1.0
// ============================================================================
package imm_ext_pkg;

    localparam logic [1:0] IMM_SIGN   = 2'b00;
    localparam logic [1:0] IMM_ZERO   = 2'b01;
    localparam logic [1:0] IMM_UPPER  = 2'b10;
    localparam logic [1:0] IMM_BRANCH = 2'b11;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Brief    : Combinational immediate extension mux (sign/zero/upper/branch).
// Revision : 1.0
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] imm_o
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_sext   = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
    assign w_zext   = {{(OUT_W-IN_W){1'b0}}, imm_i};
    assign w_upper  = {imm_i, {(OUT_W-IN_W){1'b0}}};
    // Branch offsets are word-aligned: the two MSBs of the sign extension fall off.
    assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

    always_comb begin
        imm_o = w_sext;
        case (mode_i)
            IMM_SIGN:   imm_o = w_sext;
            IMM_ZERO:   imm_o = w_zext;
            IMM_UPPER:  imm_o = w_upper;
            IMM_BRANCH: imm_o = w_branch;
            default:    imm_o = w_sext;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_stage
// Brief    : Registered immediate-extension stage with handshake, flush and
//            a saturating debug operation counter.
// Revision : 1.0
// ============================================================================
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_neg,
    output logic [CNT_W-1:0] dbg_count,
    input  logic             dbg_clear
);

    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_take;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_imm_q,   out_imm_d;
    logic             out_neg_q,   out_neg_d;
    logic [CNT_W-1:0] dbg_count_q, dbg_count_d;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .imm_o  (w_ext)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    // A flushed accept is squashed entirely: no load, no count.
    assign w_take   = w_accept && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_neg_d   = out_neg_q;
        dbg_count_d = dbg_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_take) begin
            out_imm_d = w_ext;
            out_neg_d = in_imm[IN_W-1];
        end

        if (dbg_clear) begin
            dbg_count_d = '0;
        end else if (w_take && (dbg_count_q != '1)) begin
            dbg_count_d = dbg_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_neg_q   <= 1'b0;
            dbg_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_neg_q   <= out_neg_d;
            dbg_count_q <= dbg_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_neg   = out_neg_q;
    assign dbg_count = dbg_count_q;

endmodule : imm_ext_stage
`default_nettype wire
